// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
//
// seq_shift_add_ripple_adder: WIDTH-bit ripple-carry adder used as the per-step datapath adder.
//   a_i, b_i  : addends
//   cin_i     : carry in
//   sum_o     : WIDTH-bit sum
//   cout_o    : carry out
//
// seq_shift_add_multiplier: WIDTH x WIDTH unsigned multiplier, one shift-and-add step per clock.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : request, sampled only while idle
//   a, b      : multiplicand / multiplier, captured on an accepted start
//   busy      : high from the cycle after acceptance through the done cycle
//   done      : one-cycle pulse, product valid
//   product   : 2*WIDTH-bit result, held until the next result is produced

module seq_shift_add_ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    always_comb begin
        logic [WIDTH:0] carry;
        carry    = '0;
        carry[0] = cin_i;
        sum_o    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[WIDTH];
    end

endmodule

module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     q_q;
    logic [CW-1:0]        count_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 step_c;
    logic [WIDTH-1:0]     step_sum;
    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     q_d;
    logic                 last_step;

    seq_shift_add_ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a_i    (acc_q),
        .b_i    (m_q),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // One step: conditionally add M into ACC, then shift {C,ACC,Q} right.
    // The carry is consumed by the same shift, so it never needs its own register.
    always_comb begin
        step_c    = 1'b0;
        step_sum  = acc_q;
        if (q_q[0]) begin
            step_c   = add_cout;
            step_sum = add_sum;
        end
        acc_d     = {step_c, step_sum[WIDTH-1:1]};
        q_d       = {step_sum[0], q_q[WIDTH-1:1]};
        last_step = (count_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_CALC;
                        m_q     <= a;
                        q_q     <= b;
                        acc_q   <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    count_q <= count_q + CW'(1);
                    if (last_step) begin
                        state_q   <= S_DONE;
                        product_q <= {acc_d, q_d};
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - scoreboard bench for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int prod;
        int acc_edge;
        int done_edge;
    } exp_t;

    exp_t sb[$];
    int   edge_n   = 0;
    int   next_ok  = 0;
    int   exp_prod = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Driver: one call per clock; the model decides acceptance from timing alone.
    task automatic drive(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic r);
        int e;
        @(negedge clk);
        start = st;
        a     = av;
        b     = bv;
        rst   = r;
        e     = edge_n + 1;
        if (r) begin
            sb.delete();
            exp_prod = 0;
            next_ok  = e + 1;
        end else if (st && e >= next_ok) begin
            sb.push_back('{int'(av) * int'(bv), e, e + W});
            next_ok = e + W + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        forever begin
            logic busy_exp;
            @(posedge clk);
            #2;
            busy_exp = (sb.size() > 0) && (edge_n >= sb[0].acc_edge);
            checks++;
            if (busy !== busy_exp) begin
                failures++;
                $display("FAIL busy edge=%0d actual=%0b expected=%0b", edge_n, busy, busy_exp);
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0 || sb[0].done_edge != edge_n) begin
                    failures++;
                    $display("FAIL done_unexpected edge=%0d actual=1 expected=0", edge_n);
                end else begin
                    exp_prod = sb[0].prod;
                    void'(sb.pop_front());
                end
            end else begin
                checks++;
                if (sb.size() > 0 && sb[0].done_edge == edge_n) begin
                    failures++;
                    $display("FAIL done_missing edge=%0d actual=%b expected=1", edge_n, done);
                    exp_prod = sb[0].prod;
                    void'(sb.pop_front());
                end
            end
            checks++;
            if (int'(product) != exp_prod || $isunknown(product)) begin
                failures++;
                $display("FAIL product edge=%0d actual=%0d expected=%0d", edge_n, product, exp_prod);
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        idle(2);

        drive(1'b1, 4'd5, 4'd3, 1'b0);
        idle(W + 3);

        drive(1'b1, 4'hF, 4'hF, 1'b0);
        idle(W + 3);

        drive(1'b1, 4'h8, 4'h0, 1'b0);
        idle(W + 1);
        drive(1'b1, 4'h0, 4'h9, 1'b0);
        idle(W + 3);

        drive(1'b1, 4'd2, 4'd3, 1'b0);
        idle(1);
        drive(1'b1, 4'd7, 4'd7, 1'b0);
        idle(W + 3);

        for (int i = 0; i < 20; i++) drive(1'b1, 4'd3, 4'd4, 1'b0);
        idle(W + 3);

        drive(1'b1, 4'd9, 4'd9, 1'b0);
        idle(1);
        drive(1'b0, '0, '0, 1'b1);
        idle(3);
        drive(1'b1, 4'd9, 4'd9, 1'b0);
        idle(W + 3);

        for (int i = 0; i < 400; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            drive($urandom_range(0, 2) != 0, ra, rb, $urandom_range(0, 40) == 0);
        end
        idle(W + 4);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
